// File: rtl/prio_arbiter_ctrl.sv
// N-way arbiter with registered one-hot grant, grant hold, optional round-robin
// rotation and hold-time preemption when other requesters are waiting.
module prio_arbiter_ctrl #(
    parameter int N        = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [IW-1:0] id_nxt;
    logic          to_nxt;

    logic          owner_req, others, expired, preempt;
    logic [N-1:0]  cand;
    logic          win_found;
    logic [IW-1:0] win_id;

    assign owner_req = |(req & gnt);
    assign others    = |(req & ~gnt);
    assign expired   = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
    // Release takes precedence over expiry: preemption needs the owner still requesting.
    assign preempt   = (state == GRANT) && owner_req && expired && others;
    assign cand      = preempt ? (req & ~gnt) : req;
    assign gnt_valid = |gnt;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = (RR_EN != 0) ? ((32'(ptr) + N - i) % N) : (N - 1 - i);
            if (!win_found && cand[idx[IW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        logic arb;
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        hold_nxt  = hold_cnt;
        ptr_nxt   = ptr;
        to_nxt    = 1'b0;
        arb       = 1'b0;
        case (state)
            IDLE:  arb = |req;
            GRANT: begin
                if (!owner_req || preempt) begin
                    arb    = 1'b1;
                    to_nxt = preempt;
                end else if ((MAX_HOLD != 0) && !expired) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (arb) begin
            hold_nxt = '0;
            if (win_found) begin
                state_nxt       = GRANT;
                gnt_nxt         = '0;
                gnt_nxt[win_id] = 1'b1;
                id_nxt          = win_id;
                ptr_nxt         = (win_id == '0) ? IW'(N - 1) : win_id - IW'(1);
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                id_nxt    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            ptr      <= IW'(N - 1);
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= id_nxt;
            hold_cnt <= hold_nxt;
            ptr      <= ptr_nxt;
            timeout  <= to_nxt;
        end
    end

endmodule

// File: tb/tb_prio_arbiter_ctrl.sv
// Bench for prio_arbiter_ctrl: three configurations checked against a
// cycle-level reference model plus directed scenarios.
module tb_prio_arbiter_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   [3];
    logic [N-1:0] d_gnt [3];
    logic [1:0]   d_id  [3];
    logic         d_val [3];
    logic         d_to  [3];

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance: owner index (-1 = none), cycles held, rotation pointer.
    int m_owner [3];
    int m_held  [3];
    int m_ptr   [3];
    bit m_to    [3];
    int rr_cfg  [3] = '{0, 1, 1};
    int mh_cfg  [3] = '{0, 0, 4};

    prio_arbiter_ctrl #(.N(N), .RR_EN(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .gnt(d_gnt[0]),
        .gnt_id(d_id[0]), .gnt_valid(d_val[0]), .timeout(d_to[0]));

    prio_arbiter_ctrl #(.N(N), .RR_EN(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .gnt(d_gnt[1]),
        .gnt_id(d_id[1]), .gnt_valid(d_val[1]), .timeout(d_to[1]));

    prio_arbiter_ctrl #(.N(N), .RR_EN(1), .MAX_HOLD(4)) u_hold (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .gnt(d_gnt[2]),
        .gnt_id(d_id[2]), .gnt_valid(d_val[2]), .timeout(d_to[2]));

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_ptr[k]   = N - 1;
            m_to[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [N-1:0] r);
        bit           pick;
        logic [N-1:0] c;
        logic [N-1:0] om;
        int           w;
        int           idx;
        pick    = 1'b0;
        c       = r;
        m_to[k] = 1'b0;
        om      = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
        if (m_owner[k] < 0) begin
            pick = (r != 0);
        end else if ((r & om) == 0) begin
            pick = 1'b1;
        end else if (mh_cfg[k] != 0 && m_held[k] + 1 >= mh_cfg[k] && (r & ~om) != 0) begin
            pick    = 1'b1;
            c       = r & ~om;
            m_to[k] = 1'b1;
        end else begin
            m_held[k]++;
        end
        if (pick) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                idx = (rr_cfg[k] != 0) ? (m_ptr[k] - i + N) % N : N - 1 - i;
                if (w < 0 && c[idx[1:0]]) w = idx;
            end
            m_owner[k] = w;
            m_held[k]  = 0;
            if (w >= 0) m_ptr[k] = (w + N - 1) % N;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt(input int k);
        return (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) model_step(k, req[k]);
        end
        #1;
    endtask

    task automatic test_reset();
        req[0] = 4'b0100;
        tick();
        n_cmp++;
        if (d_gnt[0] !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_pre_grant: gnt=%b want 0100", d_gnt[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (d_gnt[0] !== 4'b0000 || d_val[0] !== 1'b0 || d_id[0] !== 2'd0 || d_to[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: gnt=%b val=%b id=%0d to=%b want 0000/0/0/0",
                     d_gnt[0], d_val[0], d_id[0], d_to[0]);
        end
        model_reset();
        req[0] = 4'b0000;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (d_gnt[0] !== 4'b0000 || d_val[0] !== 1'b0 || d_to[0] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle: gnt=%b val=%b to=%b want 0000/0/0",
                         d_gnt[0], d_val[0], d_to[0]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] rv [3] = '{4'b0101, 4'b0001, 4'b0000};
        logic [N-1:0] eg [3] = '{4'b0100, 4'b0001, 4'b0000};
        int           ei [3] = '{2, 0, 0};
        for (int s = 0; s < 3; s++) begin
            req[0] = rv[s];
            tick();
            n_cmp++;
            if (d_gnt[0] !== eg[s] || d_val[0] !== (eg[s] != 0) ||
                (eg[s] != 0 && d_id[0] !== 2'(ei[s]))) begin
                n_err++;
                $display("FAIL fixed_prio step %0d: gnt=%b id=%0d want %b id=%0d",
                         s, d_gnt[0], d_id[0], eg[s], ei[s]);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{3, 2, 1, 0, 3};
        req[1] = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_cmp++;
            if (d_gnt[1] !== 4'(1 << order[s]) || d_id[1] !== 2'(order[s]) || d_val[1] !== 1'b1) begin
                n_err++;
                $display("FAIL round_robin step %0d: gnt=%b id=%0d want id=%0d",
                         s, d_gnt[1], d_id[1], order[s]);
            end
            req[1] = 4'b1111 & ~4'(1 << order[s]);
        end
        req[1] = 4'b0000;
        tick();
    endtask

    task automatic test_preempt();
        logic [N-1:0] eg [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        bit           et [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        req[2] = 4'b0011;
        for (int s = 0; s < 9; s++) begin
            tick();
            n_cmp++;
            if (d_gnt[2] !== eg[s] || d_to[2] !== et[s]) begin
                n_err++;
                $display("FAIL preempt cycle %0d: gnt=%b to=%b want %b to=%b",
                         s, d_gnt[2], d_to[2], eg[s], et[s]);
            end
        end
        req[2] = 4'b0000;
        tick();
    endtask

    task automatic test_single_owner();
        req[2] = 4'b0001;
        for (int s = 0; s < 10; s++) begin
            tick();
            n_cmp++;
            if (d_gnt[2] !== 4'b0001 || d_to[2] !== 1'b0) begin
                n_err++;
                $display("FAIL single_owner cycle %0d: gnt=%b to=%b want 0001 to=0",
                         s, d_gnt[2], d_to[2]);
            end
        end
        req[2] = 4'b0000;
        tick();
    endtask

    task automatic test_release_at_expiry();
        req[2] = 4'b0001;
        tick();
        req[2] = 4'b0011;
        repeat (3) tick();
        req[2] = 4'b0010;
        tick();
        n_cmp++;
        if (d_gnt[2] !== 4'b0010 || d_to[2] !== 1'b0) begin
            n_err++;
            $display("FAIL release_at_expiry: gnt=%b to=%b want 0010 to=0", d_gnt[2], d_to[2]);
        end
        req[2] = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                for (int b = 0; b < N; b++) begin
                    if ($urandom_range(0, 4) == 0) req[k][b] = ~req[k][b];
                end
                if ($urandom_range(0, 40) == 0) req[k] = 4'b0000;
            end
            if (c == 300) begin
                #2 rst_n = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if (d_gnt[k] !== 4'b0000 || d_val[k] !== 1'b0 || d_to[k] !== 1'b0) begin
                        n_err++;
                        $display("FAIL random_reset inst %0d: gnt=%b val=%b to=%b want 0",
                                 k, d_gnt[k], d_val[k], d_to[k]);
                    end
                end
                model_reset();
                #2 rst_n = 1'b1;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (d_gnt[k] !== exp_gnt(k) || d_val[k] !== 1'(m_owner[k] >= 0) ||
                    d_to[k] !== m_to[k] ||
                    (m_owner[k] >= 0 && d_id[k] !== 2'(m_owner[k]))) begin
                    n_err++;
                    $display("FAIL random c%0d inst %0d: gnt=%b id=%0d val=%b to=%b want gnt=%b id=%0d to=%b",
                             c, k, d_gnt[k], d_id[k], d_val[k], d_to[k],
                             exp_gnt(k), m_owner[k], m_to[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) req[k] = 4'b0000;
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_preempt();
        test_single_owner();
        test_release_at_expiry();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
